ps2_scan_decoder: RTL and testbench

- Downstream consumer of the PS/2 receive byte stream. Turns Set-2 scan-code bytes into single-pulse key events carrying make/break, extended flag and live modifier state.
- Sits between the PS/2 byte receiver and keyboard-facing logic (UART echo, LED/7-seg display, menu control).
- Strips the E0/F0/E1 prefixes and swallows keyboard housekeeping bytes.

---
 rtl/ps2_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_scan_decoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_decoder.sv
// Set-2 scan-code decoder: strips E0/F0/E1 prefixes and emits one-cycle key events with live modifier state.
// Optional ASCII translation is built only when PS2_DEC_ASCII_EN is defined; otherwise ascii_o is tied to 00.
module ps2_scan_decoder #(
  parameter int PAUSE_LEN = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       byte_vld_i,
  input  logic [7:0] byte_in_i,
  output logic       key_vld_o,
  output logic [7:0] key_code_o,
  output logic       key_ext_o,
  output logic       key_brk_o,
  output logic       mod_shift_o,
  output logic       mod_ctrl_o,
  output logic       caps_lock_o,
  output logic [7:0] ascii_o
);

  localparam int CW = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          emit, emit_ext, emit_brk;
  logic          is_ign, is_pfx;
  logic          lshift_q, lshift_d, rshift_q, rshift_d;
  logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic          caps_q, caps_d, caps_held_q, caps_held_d;
  logic          key_vld_q, key_ext_q, key_brk_q, mod_shift_q, mod_ctrl_q;
  logic [7:0]    key_code_q, ascii_q, ascii_d;

  assign is_ign = byte_in_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
  assign is_pfx = byte_in_i inside {8'hE0, 8'hF0, 8'hE1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (byte_vld_i) begin
      case (state_q)
        IDLE: begin
          if (is_ign) state_d = IDLE;
          else if (byte_in_i == 8'hE0) state_d = EXT;
          else if (byte_in_i == 8'hF0) state_d = BRK;
          else if (byte_in_i == 8'hE1) begin
            state_d = PAUSE;
            cnt_d   = CW'(PAUSE_LEN);
          end else emit = 1'b1;
        end
        EXT: begin
          if (is_ign) state_d = IDLE;
          else if (byte_in_i == 8'hF0) state_d = EXT_BRK;
          else if (byte_in_i == 8'hE0) state_d = EXT;
          else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          // A prefix after F0 is a protocol error; drop the whole sequence silently.
          state_d = IDLE;
          if (!is_ign && !is_pfx) begin
            emit     = 1'b1;
            emit_ext = (state_q == EXT_BRK);
            emit_brk = 1'b1;
          end
        end
        PAUSE: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q - CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_DEC_ASCII_EN
  function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic shift,
                                            input logic caps);
    logic [7:0] base, alt;
    logic       letter;
    base = 8'h00;
    alt  = 8'h00;
    case (code)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
      8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
      8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
      8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
      8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h45: begin base = "0"; alt = ")"; end
      8'h16: begin base = "1"; alt = "!"; end
      8'h1E: begin base = "2"; alt = "@"; end
      8'h26: begin base = "3"; alt = "#"; end
      8'h25: begin base = "4"; alt = "$"; end
      8'h2E: begin base = "5"; alt = "%"; end
      8'h36: begin base = "6"; alt = "^"; end
      8'h3D: begin base = "7"; alt = "&"; end
      8'h3E: begin base = "8"; alt = "*"; end
      8'h46: begin base = "9"; alt = "("; end
      8'h0E: begin base = 8'h60; alt = 8'h7E; end
      8'h4E: begin base = 8'h2D; alt = 8'h5F; end
      8'h55: begin base = 8'h3D; alt = 8'h2B; end
      8'h54: begin base = 8'h5B; alt = 8'h7B; end
      8'h5B: begin base = 8'h5D; alt = 8'h7D; end
      8'h5D: begin base = 8'h5C; alt = 8'h7C; end
      8'h4C: begin base = 8'h3B; alt = 8'h3A; end
      8'h52: begin base = 8'h27; alt = 8'h22; end
      8'h41: begin base = 8'h2C; alt = 8'h3C; end
      8'h49: begin base = 8'h2E; alt = 8'h3E; end
      8'h4A: begin base = 8'h2F; alt = 8'h3F; end
      8'h29: begin base = 8'h20; alt = 8'h20; end
      8'h5A: begin base = 8'h0D; alt = 8'h0D; end
      8'h66: begin base = 8'h08; alt = 8'h08; end
      default: begin base = 8'h00; alt = 8'h00; end
    endcase
    letter = (base >= "a") && (base <= "z");
    if (letter) return (shift ^ caps) ? (base - 8'h20) : base;
    return shift ? alt : base;
  endfunction
`endif

  // Modifiers and caps are resolved here so the event carries its own effect on them.
  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    ascii_d     = 8'h00;
    if (emit) begin
      if (!emit_ext && byte_in_i == 8'h12) lshift_d = !emit_brk;
      if (!emit_ext && byte_in_i == 8'h59) rshift_d = !emit_brk;
      if (!emit_ext && byte_in_i == 8'h14) lctrl_d  = !emit_brk;
      if ( emit_ext && byte_in_i == 8'h14) rctrl_d  = !emit_brk;
      if (!emit_ext && byte_in_i == 8'h58) begin
        if (emit_brk) caps_held_d = 1'b0;
        else begin
          if (!caps_held_q) caps_d = !caps_q;
          caps_held_d = 1'b1;
        end
      end
`ifdef PS2_DEC_ASCII_EN
      if (!emit_ext && !emit_brk) ascii_d = set2_ascii(byte_in_i, lshift_d | rshift_d, caps_d);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      key_vld_q   <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_brk_q   <= 1'b0;
      ascii_q     <= 8'h00;
      mod_shift_q <= 1'b0;
      mod_ctrl_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      key_vld_q   <= emit;
      mod_shift_q <= lshift_d | rshift_d;
      mod_ctrl_q  <= lctrl_d | rctrl_d;
      if (emit) begin
        key_code_q <= byte_in_i;
        key_ext_q  <= emit_ext;
        key_brk_q  <= emit_brk;
        ascii_q    <= ascii_d;
      end
    end
  end

  assign key_vld_o   = key_vld_q;
  assign key_code_o  = key_code_q;
  assign key_ext_o   = key_ext_q;
  assign key_brk_o   = key_brk_q;
  assign mod_shift_o = mod_shift_q;
  assign mod_ctrl_o  = mod_ctrl_q;
  assign caps_lock_o = caps_q;
  assign ascii_o     = ascii_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: a key-state model checked every cycle plus literal spot checks.
// Expected ASCII values follow PS2_DEC_ASCII_EN in the same way the design does.
module tb_ps2_scan_decoder;

  localparam int PAUSE_LEN = 7;

  logic       clk, rst, byteVld;
  logic [7:0] byteIn;
  logic       keyVld, keyExt, keyBrk, modShift, modCtrl, capsLock;
  logic [7:0] keyCode, ascii;

  int assertions = 0;
  int failures   = 0;
  bit chkEn      = 0;

  ps2_scan_decoder #(.PAUSE_LEN(PAUSE_LEN)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .byte_vld_i (byteVld),
    .byte_in_i  (byteIn),
    .key_vld_o  (keyVld),
    .key_code_o (keyCode),
    .key_ext_o  (keyExt),
    .key_brk_o  (keyBrk),
    .mod_shift_o(modShift),
    .mod_ctrl_o (modCtrl),
    .caps_lock_o(capsLock),
    .ascii_o    (ascii)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model state: pending prefixes, a pause byte budget and a held-key table indexed by {ext, code}.
  logic       expVld, expExt, expBrk, expShift, expCtrl, expCaps;
  logic [7:0] expCode, expAscii;
  bit         pendExt, pendBrk;
  int         pauseLeft;
  bit         held [512];

`ifdef PS2_DEC_ASCII_EN
  logic [7:0] normTab [256];
  logic [7:0] shTab   [256];
  bit         letTab  [256];
  logic [7:0] letCode [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digCode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pncCode [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41,
                               8'h49, 8'h4A};
  string digShift = ")!@#$%^&*(";
  logic [7:0] pncNorm  [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C,
                                8'h2E, 8'h2F};
  logic [7:0] pncShift [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C,
                                8'h3E, 8'h3F};

  initial begin
    for (int i = 0; i < 256; i++) begin
      normTab[i] = 8'h00;
      shTab[i]   = 8'h00;
      letTab[i]  = 0;
    end
    for (int i = 0; i < 26; i++) begin
      normTab[letCode[i]] = 8'h61 + 8'(i);
      shTab[letCode[i]]   = 8'h41 + 8'(i);
      letTab[letCode[i]]  = 1;
    end
    for (int i = 0; i < 10; i++) begin
      normTab[digCode[i]] = 8'h30 + 8'(i);
      shTab[digCode[i]]   = digShift[i];
    end
    for (int i = 0; i < 11; i++) begin
      normTab[pncCode[i]] = pncNorm[i];
      shTab[pncCode[i]]   = pncShift[i];
    end
    normTab[8'h29] = 8'h20; shTab[8'h29] = 8'h20;
    normTab[8'h5A] = 8'h0D; shTab[8'h5A] = 8'h0D;
    normTab[8'h66] = 8'h08; shTab[8'h66] = 8'h08;
  end
`endif

  function automatic logic [7:0] modelAscii(input logic [7:0] c, input bit ext, input bit brk,
                                            input bit sh, input bit caps);
`ifdef PS2_DEC_ASCII_EN
    if (ext || brk) return 8'h00;
    if (letTab[c]) return (sh ^ caps) ? shTab[c] : normTab[c];
    return sh ? shTab[c] : normTab[c];
`else
    return 8'h00;
`endif
  endfunction

  task automatic modelEmit(input logic [7:0] c, input bit ext, input bit brk);
    if (!ext && !brk && c == 8'h58 && !held[9'h058]) expCaps = !expCaps;
    held[{ext, c}] = !brk;
    expShift = held[9'h012] | held[9'h059];
    expCtrl  = held[9'h014] | held[9'h114];
    expVld   = 1;
    expCode  = c;
    expExt   = ext;
    expBrk   = brk;
    expAscii = modelAscii(c, ext, brk, expShift, expCaps);
  endtask

  task automatic modelByte(input logic [7:0] b);
    bit ign, pfx;
    ign = b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    pfx = b inside {8'hE0, 8'hF0, 8'hE1};
    if (pauseLeft > 0) pauseLeft--;
    else if (ign) begin
      pendExt = 0;
      pendBrk = 0;
    end else if (pendBrk) begin
      if (!pfx) modelEmit(b, pendExt, 1);
      pendExt = 0;
      pendBrk = 0;
    end else if (b == 8'hF0) pendBrk = 1;
    else if (b == 8'hE0) pendExt = 1;
    else if (b == 8'hE1 && !pendExt) pauseLeft = PAUSE_LEN;
    else begin
      modelEmit(b, pendExt, 0);
      pendExt = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expVld = 0; expExt = 0; expBrk = 0; expShift = 0; expCtrl = 0; expCaps = 0;
      expCode = 8'h00; expAscii = 8'h00;
      pendExt = 0; pendBrk = 0; pauseLeft = 0;
      for (int i = 0; i < 512; i++) held[i] = 0;
    end else begin
      expVld = 0;
      if (byteVld) modelByte(byteIn);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!rst && chkEn) begin
      assertions++;
      if (keyVld !== expVld || keyCode !== expCode || keyExt !== expExt || keyBrk !== expBrk ||
          modShift !== expShift || modCtrl !== expCtrl || capsLock !== expCaps ||
          ascii !== expAscii) begin
        failures++;
        $display("[TB] FAIL cycleModel t=%0t actual vld=%b code=%h ext=%b brk=%b sh=%b ctl=%b caps=%b asc=%h required vld=%b code=%h ext=%b brk=%b sh=%b ctl=%b caps=%b asc=%h",
                 $time, keyVld, keyCode, keyExt, keyBrk, modShift, modCtrl, capsLock, ascii,
                 expVld, expCode, expExt, expBrk, expShift, expCtrl, expCaps, expAscii);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    assertions++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a falling edge; consecutive calls give back-to-back strobes.
  task automatic applyStimulus(input logic [7:0] b);
    byteVld = 1;
    byteIn  = b;
    @(negedge clk);
    byteVld = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1; byteVld = 0; byteIn = 8'h00;
    repeat (3) @(negedge clk);
    rst = 0;
    chkEn = 1;
    checkOutput("rst_vld", {7'b0, keyVld}, 8'h00);
    checkOutput("rst_code", keyCode, 8'h00);
    checkOutput("rst_mods", {5'b0, modShift, modCtrl, capsLock}, 8'h00);
    checkOutput("rst_ascii", ascii, 8'h00);

    applyStimulus(8'h1C);
    checkOutput("a_vld", {7'b0, keyVld}, 8'h01);
    checkOutput("a_code", keyCode, 8'h1C);
    checkOutput("a_extbrk", {6'b0, keyExt, keyBrk}, 8'h00);
`ifdef PS2_DEC_ASCII_EN
    checkOutput("a_ascii", ascii, 8'h61);
`else
    checkOutput("a_ascii", ascii, 8'h00);
`endif
    idle(2);
    checkOutput("a_hold", {keyCode[6:0], keyVld}, {7'h1C, 1'b0});

    applyStimulus(8'h12);
    applyStimulus(8'h1C);
    checkOutput("A_shift", {7'b0, modShift}, 8'h01);
`ifdef PS2_DEC_ASCII_EN
    checkOutput("A_ascii", ascii, 8'h41);
`endif
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("A_brk", {7'b0, keyBrk}, 8'h01);
    checkOutput("A_brk_ascii", ascii, 8'h00);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    checkOutput("shift_rel", {7'b0, modShift}, 8'h00);
    idle(1);

    applyStimulus(8'hE0);
    checkOutput("pfx_novld", {7'b0, keyVld}, 8'h00);
    applyStimulus(8'h75);
    checkOutput("ext_make", {keyCode, 7'b0, keyExt, keyBrk}, {8'h75, 7'b0, 1'b1, 1'b0});
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    checkOutput("ext_brk", {keyCode, 7'b0, keyExt, keyBrk}, {8'h75, 7'b0, 1'b1, 1'b1});

    applyStimulus(8'hE0); applyStimulus(8'h14); applyStimulus(8'h14);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h14);
    checkOutput("ctrl_one_held", {7'b0, modCtrl}, 8'h01);
    applyStimulus(8'hF0); applyStimulus(8'h14);
    checkOutput("ctrl_rel", {7'b0, modCtrl}, 8'h00);
    applyStimulus(8'h59); applyStimulus(8'h12);
    applyStimulus(8'hF0); applyStimulus(8'h59);
    checkOutput("shift_one_held", {7'b0, modShift}, 8'h01);
    applyStimulus(8'hF0); applyStimulus(8'h12);
    idle(1);

    applyStimulus(8'h58);
    checkOutput("caps_on", {7'b0, capsLock}, 8'h01);
    applyStimulus(8'h58); applyStimulus(8'h58);
    checkOutput("caps_repeat", {7'b0, capsLock}, 8'h01);
    applyStimulus(8'hF0); applyStimulus(8'h58);
    applyStimulus(8'h58);
    checkOutput("caps_off", {7'b0, capsLock}, 8'h00);
    applyStimulus(8'h1C);
`ifdef PS2_DEC_ASCII_EN
    checkOutput("caps_off_ascii", ascii, 8'h61);
`endif
    applyStimulus(8'hF0); applyStimulus(8'h58); applyStimulus(8'h58);
    applyStimulus(8'h12); applyStimulus(8'h1C);
    checkOutput("caps_shift_mods", {6'b0, capsLock, modShift}, 8'h03);
`ifdef PS2_DEC_ASCII_EN
    checkOutput("caps_shift_ascii", ascii, 8'h61);
    applyStimulus(8'h16);
    checkOutput("digit_shift_ascii", ascii, 8'h21);
`endif
    applyStimulus(8'hF0); applyStimulus(8'h12);
    applyStimulus(8'hF0); applyStimulus(8'h58);
    applyStimulus(8'h58);
    checkOutput("caps_restore", {7'b0, capsLock}, 8'h00);
    idle(1);

    applyStimulus(8'hE1); applyStimulus(8'h14); applyStimulus(8'h77); applyStimulus(8'hE1);
    applyStimulus(8'hF0); applyStimulus(8'h14); applyStimulus(8'hF0); applyStimulus(8'h77);
    checkOutput("pause_silent", {6'b0, keyVld, modCtrl}, 8'h00);
    applyStimulus(8'h16);
    checkOutput("after_pause", keyCode, 8'h16);
`ifdef PS2_DEC_ASCII_EN
    checkOutput("after_pause_ascii", ascii, 8'h31);
`endif
    applyStimulus(8'hE1); applyStimulus(8'hFA); applyStimulus(8'hAA); applyStimulus(8'h00);
    applyStimulus(8'hFF); applyStimulus(8'hEE); applyStimulus(8'hFE); applyStimulus(8'hFC);
    applyStimulus(8'h1C);
    checkOutput("pause_ign_count", {keyCode, 7'b0, keyVld}, {8'h1C, 8'h01});

    applyStimulus(8'hE0); applyStimulus(8'hAA); applyStimulus(8'h1C);
    checkOutput("ign_abort_ext", {7'b0, keyExt}, 8'h00);
    applyStimulus(8'hF0); applyStimulus(8'hFA); applyStimulus(8'h1C);
    checkOutput("ign_abort_brk", {7'b0, keyBrk}, 8'h00);
    applyStimulus(8'hF0); applyStimulus(8'hE0);
    checkOutput("proto_err_novld", {7'b0, keyVld}, 8'h00);
    applyStimulus(8'h75);
    checkOutput("proto_err_plain", {6'b0, keyExt, keyBrk}, 8'h00);
    idle(1);

    applyStimulus(8'h12);
    applyStimulus(8'hF0);
    rst = 1;
    idle(2);
    rst = 0;
    applyStimulus(8'h1C);
    checkOutput("rst_mid_brk", {7'b0, keyBrk}, 8'h00);
    checkOutput("rst_mid_mods", {5'b0, modShift, modCtrl, capsLock}, 8'h00);
    idle(3);

    chkEn = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
